// File: rtl/muldiv_pkg.sv
// Shared constants, encodings and helpers for the HI/LO multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned WIDTH   = 32;
    localparam int unsigned COUNT_W = $clog2(WIDTH);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Operation context captured when a request is accepted
    typedef struct packed {
        logic [1:0] op;
        logic       signA;
        logic       signB;
        logic       divZero;
    } opCtx_t;

    function automatic logic isSignedOp(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic isDivOp(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/hilo_muldiv_unit_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
interface hilo_muldiv_unit_if;
    import muldiv_pkg::*;

    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] OperandA;
    logic [WIDTH-1:0] OperandB;
    logic             Flush;
    logic             Busy;
    logic             Stall;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, OperandA, OperandB, Flush,
        input  Busy, Stall, Done, Hi, Lo
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, Flush,
        output Busy, Stall, Done, Hi, Lo
    );

endinterface

// File: rtl/muldiv_sign_adjust.sv
// Sign handling around the unsigned iteration core: magnitudes in, signed results out.
module muldiv_sign_adjust
    import muldiv_pkg::*;
(
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             signedOp,
    input  logic             isDiv,
    input  logic             signA,
    input  logic             signB,
    input  logic             divZero,
    input  logic [WIDTH-1:0] resHi,
    input  logic [WIDTH-1:0] resLo,
    output logic [WIDTH-1:0] absA_c,
    output logic [WIDTH-1:0] absB_c,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    logic             negate;
    logic [2*WIDTH-1:0] prod;

    // Magnitudes on entry, sign restoration on the final iteration
    always_comb begin
        absA_c = opA;
        absB_c = opB;
        negate = signA ^ signB;
        prod   = {resHi, resLo};
        hi_c   = resHi;
        lo_c   = resLo;
        if (signedOp && opA[WIDTH-1]) absA_c = -opA;
        if (signedOp && opB[WIDTH-1]) absB_c = -opB;
        if (isDiv) begin
            // Divide by zero: quotient forced to all-ones, remainder returns the dividend
            lo_c = divZero ? '1 : (negate ? -resLo : resLo);
            hi_c = signA ? -resHi : resHi;
        end else begin
            if (negate) prod = -prod;
            hi_c = prod[2*WIDTH-1:WIDTH];
            lo_c = prod[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative 32-step multiply/divide unit producing {Hi, Lo} for MULT/MULTU/DIV/DIVU.
module hilo_muldiv_unit
    import muldiv_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst,
    hilo_muldiv_unit_if.slave bus
);

    logic [1:0]         state, stateNext;
    logic               busyQ, busyNext;
    logic               doneQ, doneNext;
    logic               accept, lastIter;
    logic [COUNT_W-1:0] count;
    opCtx_t             ctx;
    logic [WIDTH-1:0]   accHi, accHiNext;
    logic [WIDTH-1:0]   accLo, accLoNext;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   hiQ, loQ;
    logic [WIDTH-1:0]   absA_c, absB_c, hi_c, lo_c;
    logic [WIDTH:0]     sum, shifted, diff;

    // State and registered status flags
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state <= IDLE;
            busyQ <= 1'b0;
            doneQ <= 1'b0;
        end else begin
            state <= stateNext;
            busyQ <= busyNext;
            doneQ <= doneNext;
        end
    end

    // Next state and next status; Flush only matters while iterating
    always_comb begin
        stateNext = state;
        busyNext  = 1'b0;
        doneNext  = 1'b0;
        accept    = 1'b0;
        lastIter  = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.Start) begin
                    stateNext = RUN;
                    busyNext  = 1'b1;
                    accept    = 1'b1;
                end else begin
                    stateNext = IDLE;
                end
            end
            RUN: begin
                if (bus.Flush) begin
                    stateNext = IDLE;
                end else if (count == COUNT_W'(WIDTH - 1)) begin
                    stateNext = DONE;
                    doneNext  = 1'b1;
                    lastIter  = 1'b1;
                end else begin
                    busyNext  = 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // One iteration: shift-add multiply or restoring divide step
    always_comb begin
        sum       = '0;
        shifted   = '0;
        diff      = '0;
        accHiNext = accHi;
        accLoNext = accLo;
        if (isDivOp(ctx.op)) begin
            shifted = {accHi, accLo[WIDTH-1]};
            diff    = shifted - {1'b0, opnd};
            if (!diff[WIDTH]) begin
                accHiNext = diff[WIDTH-1:0];
                accLoNext = {accLo[WIDTH-2:0], 1'b1};
            end else begin
                accHiNext = shifted[WIDTH-1:0];
                accLoNext = {accLo[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum       = {1'b0, accHi} + (accLo[0] ? {1'b0, opnd} : (WIDTH + 1)'(0));
            accHiNext = sum[WIDTH:1];
            accLoNext = {sum[0], accLo[WIDTH-1:1]};
        end
    end

    muldiv_sign_adjust u_signAdjust (
        .opA      (bus.OperandA),
        .opB      (bus.OperandB),
        .signedOp (isSignedOp(bus.Op)),
        .isDiv    (isDivOp(ctx.op)),
        .signA    (ctx.signA),
        .signB    (ctx.signB),
        .divZero  (ctx.divZero),
        .resHi    (accHiNext),
        .resLo    (accLoNext),
        .absA_c   (absA_c),
        .absB_c   (absB_c),
        .hi_c     (hi_c),
        .lo_c     (lo_c)
    );

    // Operand capture, iteration registers and the Hi/Lo result pair
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            ctx   <= '0;
            count <= '0;
            accHi <= '0;
            accLo <= '0;
            opnd  <= '0;
            hiQ   <= '0;
            loQ   <= '0;
        end else begin
            if (accept) begin
                ctx.op      <= bus.Op;
                ctx.signA   <= isSignedOp(bus.Op) & bus.OperandA[WIDTH-1];
                ctx.signB   <= isSignedOp(bus.Op) & bus.OperandB[WIDTH-1];
                ctx.divZero <= (bus.OperandB == '0);
                count       <= '0;
                accHi       <= '0;
                accLo       <= isDivOp(bus.Op) ? absA_c : absB_c;
                opnd        <= isDivOp(bus.Op) ? absB_c : absA_c;
            end else if ((state == RUN) && !bus.Flush) begin
                accHi <= accHiNext;
                accLo <= accLoNext;
                count <= count + COUNT_W'(1);
            end
            if (lastIter) begin
                hiQ <= hi_c;
                loQ <= lo_c;
            end
        end
    end

    assign bus.Busy  = busyQ;
    assign bus.Stall = busyQ;
    assign bus.Done  = doneQ;
    assign bus.Hi    = hiQ;
    assign bus.Lo    = loQ;

endmodule
